// File: rtl/ram_pkg.sv
// Shared constants for the FIFO controller and its external dual-port RAM.
package ram_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF      = 256;
  localparam int unsigned RAM_RD_LATENCY = 1;

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam int unsigned ADDR_W_DEF = addr_w(DEPTH_DEF);

endpackage

// File: rtl/fifo_ptr.sv
// Enable-gated wrapping pointer of W bits; the MSB is the lap bit, only the
// lower W-1 bits are presented as the RAM address.
module fifo_ptr #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-2:0] addr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign addr_o = ptr_q[W-2:0];

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM with
// registered read data; holds only pointers, occupancy and status flags.
module fifo_ctrl
  import ram_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int unsigned DEPTH      = DEPTH_DEF,
  parameter  int unsigned AF_LEVEL   = DEPTH - 4,
  localparam int unsigned ADDR_W     = addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_re,
  output logic [ADDR_W-1:0]     ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);

  logic              wr_acc, rd_acc;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d, af_q, af_d;
  logic              rd_valid_q, overflow_q, underflow_q;

  // rst_n gating keeps the RAM strobes low in reset, where full=0 alone would not.
  assign wr_acc = wr_en & ~full_q  & rst_n;
  assign rd_acc = rd_en & ~empty_q & rst_n;

  fifo_ptr #(.W(ADDR_W + 1)) u_wptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (wr_acc),
    .addr_o (waddr)
  );

  fifo_ptr #(.W(ADDR_W + 1)) u_rptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (rd_acc),
    .addr_o (raddr)
  );

  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      rd_valid_q  <= rd_acc;
      overflow_q  <= wr_en & full_q;
      underflow_q <= rd_en & empty_q;
    end
  end

  assign ram_we      = wr_acc;
  assign ram_waddr   = waddr;
  assign ram_wdata   = wr_data;
  assign ram_re      = rd_acc;
  assign ram_raddr   = raddr;
  assign rd_data     = ram_rdata;
  assign rd_valid    = rd_valid_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl with a 1-cycle-latency RAM model.
module tb_fifo_ctrl;

  localparam int DW = 8;
  localparam int DEPTH = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en;
  logic [DW-1:0] wr_data, rd_data, ram_wdata, ram_rdata;
  logic          rd_valid, full, empty, almost_full, overflow, underflow;
  logic [AW:0]   count;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_waddr, ram_raddr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(DEPTH - 4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .ram_we      (ram_we),
    .ram_waddr   (ram_waddr),
    .ram_wdata   (ram_wdata),
    .ram_re      (ram_re),
    .ram_raddr   (ram_raddr),
    .ram_rdata   (ram_rdata)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  always @(negedge clk) begin
    if (ram_we && ram_re && ram_waddr == ram_raddr) begin
      n_fail++;
      $display("FAIL ram_collision addr %0d", ram_waddr);
    end
  end

  task automatic do_reset();
    wr_en = 1'b0; rd_en = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_en = 1'b1; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    wr_en = 1'b1; wr_data = 8'h99; rd_en = 1'b1;
    rst_n = 1'b1; #1; rst_n = 1'b0; #2;
    n_checks++; if (count !== 9'd0)     begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_checks++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_checks++; if (full !== 1'b0)      begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got %b exp 0", almost_full); end
    n_checks++; if (ram_we !== 1'b0)    begin n_fail++; $display("FAIL reset_ram_we got %b exp 0", ram_we); end
    n_checks++; if (ram_re !== 1'b0)    begin n_fail++; $display("FAIL reset_ram_re got %b exp 0", ram_re); end
    @(posedge clk); #1;
    n_checks++; if (rd_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow got %b exp 0", underflow); end
    n_checks++; if (count !== 9'd0)     begin n_fail++; $display("FAIL reset_count_held got %0d exp 0", count); end
    wr_en = 1'b0; rd_en = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    do_reset();
    for (int i = 0; i < 3; i++) push(exp_d[i]);
    n_checks++; if (count !== 9'd3) begin n_fail++; $display("FAIL basic_count got %0d exp 3", count); end
    for (int i = 0; i < 3; i++) begin
      pop();
      n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_rd_valid[%0d] got %b exp 1", i, rd_valid); end
      n_checks++; if (rd_data !== exp_d[i]) begin n_fail++; $display("FAIL basic_rd_data[%0d] got %h exp %h", i, rd_data, exp_d[i]); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got %b exp 1", empty); end
    @(posedge clk); #1;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_rd_valid_idle got %b exp 0", rd_valid); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      push(8'(i));
      if (i == 250) begin
        n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL fill_af_251 got %b exp 0", almost_full); end
      end
      if (i == 251) begin
        n_checks++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL fill_af_252 got %b exp 1", almost_full); end
      end
      if (i == 254) begin
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL fill_full_255 got %b exp 0", full); end
      end
    end
    n_checks++; if (full !== 1'b1)    begin n_fail++; $display("FAIL fill_full_256 got %b exp 1", full); end
    n_checks++; if (count !== 9'd256) begin n_fail++; $display("FAIL fill_count got %0d exp 256", count); end
    wr_en = 1'b1; wr_data = 8'hEE; #1;
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL ovf_ram_we got %b exp 0", ram_we); end
    @(posedge clk); #1;
    wr_en = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %b exp 1", overflow); end
    n_checks++; if (count !== 9'd256)  begin n_fail++; $display("FAIL ovf_count got %0d exp 256", count); end
    @(posedge clk); #1;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle got %b exp 0", overflow); end
  endtask

  task automatic test_full_pushpop();
    wr_en = 1'b1; wr_data = 8'hAA; rd_en = 1'b1; #1;
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL fullpp_ram_we got %b exp 0", ram_we); end
    n_checks++; if (ram_re !== 1'b1) begin n_fail++; $display("FAIL fullpp_ram_re got %b exp 1", ram_re); end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    n_checks++; if (count !== 9'd255)  begin n_fail++; $display("FAIL fullpp_count got %0d exp 255", count); end
    n_checks++; if (full !== 1'b0)     begin n_fail++; $display("FAIL fullpp_full got %b exp 0", full); end
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL fullpp_rd_valid got %b exp 1", rd_valid); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL fullpp_rd_data got %h exp 00", rd_data); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fullpp_overflow got %b exp 1", overflow); end
    n_checks++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL fullpp_af got %b exp 1", almost_full); end
  endtask

  task automatic test_empty_pushpop();
    do_reset();
    wr_en = 1'b1; wr_data = 8'h5C; rd_en = 1'b1; #1;
    n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL emptypp_ram_we got %b exp 1", ram_we); end
    n_checks++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL emptypp_ram_re got %b exp 0", ram_re); end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    n_checks++; if (count !== 9'd1)     begin n_fail++; $display("FAIL emptypp_count got %0d exp 1", count); end
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL emptypp_underflow got %b exp 1", underflow); end
    n_checks++; if (rd_valid !== 1'b0)  begin n_fail++; $display("FAIL emptypp_rd_valid got %b exp 0", rd_valid); end
    n_checks++; if (empty !== 1'b0)     begin n_fail++; $display("FAIL emptypp_empty got %b exp 0", empty); end
    pop();
    n_checks++; if (rd_valid !== 1'b1)  begin n_fail++; $display("FAIL emptypp_pop_valid got %b exp 1", rd_valid); end
    n_checks++; if (rd_data !== 8'h5C)  begin n_fail++; $display("FAIL emptypp_pop_data got %h exp 5c", rd_data); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL emptypp_udf_clear got %b exp 0", underflow); end
    n_checks++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL emptypp_empty_end got %b exp 1", empty); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] e;
    do_reset();
    for (int i = 0; i < 200; i++) push(8'(i * 3));
    n_checks++; if (count !== 9'd200) begin n_fail++; $display("FAIL wrap_count_fill got %0d exp 200", count); end
    for (int i = 0; i < 200; i++) begin
      pop();
      e = 8'(i * 3);
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== e) begin n_fail++; $display("FAIL wrap_drain[%0d] valid %b data %h exp 1 %h", i, rd_valid, rd_data, e); end
    end
    n_checks++; if (count !== 9'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL wrap_drained count %0d empty %b exp 0 1", count, empty); end
    for (int i = 0; i < 100; i++) begin
      push(8'(i) ^ 8'hA5);
      n_checks++; if (count !== 9'(i + 1)) begin n_fail++; $display("FAIL wrap_refill_count[%0d] got %0d exp %0d", i, count, i + 1); end
    end
    for (int i = 0; i < 100; i++) begin
      pop();
      e = 8'(i) ^ 8'hA5;
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== e) begin n_fail++; $display("FAIL wrap_redrain[%0d] valid %b data %h exp 1 %h", i, rd_valid, rd_data, e); end
    end
    n_checks++; if (count !== 9'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL wrap_end count %0d empty %b exp 0 1", count, empty); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 10; i++) push(8'(i + 8'h40));
    n_checks++; if (count !== 9'd10) begin n_fail++; $display("FAIL mid_count_pre got %0d exp 10", count); end
    rd_en = 1'b1; #2;
    rst_n = 1'b0; #1;
    n_checks++; if (count !== 9'd0) begin n_fail++; $display("FAIL mid_count got %0d exp 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty got %b exp 1", empty); end
    n_checks++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL mid_ram_re got %b exp 0", ram_re); end
    @(posedge clk); #1;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rd_valid got %b exp 0", rd_valid); end
    rd_en = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rd_valid !== 1'b0 || count !== 9'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL mid_after valid %b count %0d empty %b exp 0 0 1", rd_valid, count, empty); end
  endtask

  initial begin
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    test_reset();
    test_basic();
    test_fill();
    test_full_pushpop();
    test_empty_pushpop();
    test_wrap();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
